// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot-low column drive, synchronized row sense,
// full-scan snapshot debounce and single-key acceptance with a one-cycle strobe.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic [3:0]  rs;
  logic [15:0] contrib, snap;
  logic        term, scan_done, stable, one_hot;
  logic [3:0]  idx;

  always_comb begin
    rs        = ~row_s2_q;
    term      = (div_q == DIV_MAX);
    scan_done = term && (col_q == 2'd3);
    div_d     = term ? '0 : div_q + 1'b1;
    col_d     = term ? col_q + 2'd1 : col_q;
    // Rows land in bits 4*row; shifting by column places them at 4*row+col.
    contrib = {3'b0, rs[3], 3'b0, rs[2], 3'b0, rs[1], 3'b0, rs[0]} << col_q;
    snap    = buf_q | contrib;
    buf_d   = buf_q;
    if (term) begin
      buf_d = scan_done ? '0 : snap;
    end
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (scan_done) begin
      prev_d = snap;
      if (snap == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
    stable  = scan_done && (cnt_d == CNT_MAX);
    one_hot = (snap != 16'd0) && ((snap & (snap - 16'd1)) == 16'd0);
    idx     = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable && one_hot) begin
          code_d  = idx;
          valid_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (stable && (snap == 16'd0)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      col_q    <= 2'd0;
      buf_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      div_q    <= div_d;
      col_q    <= col_d;
      buf_q    <= buf_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model
// (SCAN_DIV=4, DEBOUNCE_SCANS=3: one scan is 16 cycles).
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_bad = 0;
  int kc = 0;
  int vcount = 0;
  bit dbl = 0;
  bit prev_v = 0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_n(col_n),
    .row_n(row_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) vcount++;
    if (key_valid && prev_v) dbl = 1;
    prev_v = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    kc += n;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 0;
    vcount = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    kc = 0;
  endtask

  task automatic test_reset;
    keys = 16'h0;
    @(negedge clk);
    reset = 0;
    #1;
    n_cmp++;
    if ({col_n, key_code, key_valid, key_held} !== 10'b1110_0000_0_0) begin
      n_bad++;
      $display("FAIL rst_out: got col=%b code=%h v=%b h=%b want 1110/0/0/0",
               col_n, key_code, key_valid, key_held);
    end
    repeat (3) @(negedge clk);
    reset = 1;
    kc = 0;
    vcount = 0;
    n_cmp++;
    if (col_n !== 4'b1110) begin
      n_bad++; $display("FAIL col_k0: got %b want 1110", col_n);
    end
    tick(3);
    n_cmp++;
    if (col_n !== 4'b1110) begin
      n_bad++; $display("FAIL col_k3: got %b want 1110", col_n);
    end
    tick(1);
    n_cmp++;
    if (col_n !== 4'b1101) begin
      n_bad++; $display("FAIL col_k4: got %b want 1101", col_n);
    end
    tick(4);
    n_cmp++;
    if (col_n !== 4'b1011) begin
      n_bad++; $display("FAIL col_k8: got %b want 1011", col_n);
    end
    tick(4);
    n_cmp++;
    if (col_n !== 4'b0111) begin
      n_bad++; $display("FAIL col_k12: got %b want 0111", col_n);
    end
    tick(4);
    n_cmp++;
    if (col_n !== 4'b1110) begin
      n_bad++; $display("FAIL col_k16: got %b want 1110", col_n);
    end
    tick(184);
    n_cmp++;
    if (vcount !== 0 || key_held !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_200: got pulses=%0d held=%b want 0/0",
               vcount, key_held);
    end
  endtask

  task automatic test_single_key;
    keys = 16'h0200;
    apply_reset();
    tick(47);
    n_cmp++;
    if (key_held !== 1'b0) begin
      n_bad++; $display("FAIL held_k47: got %b want 0", key_held);
    end
    tick(1);
    n_cmp++;
    if ({key_valid, key_held, key_code} !== 6'b1_1_1001) begin
      n_bad++;
      $display("FAIL accept_k48: got v=%b h=%b code=%h want 1/1/9",
               key_valid, key_held, key_code);
    end
    tick(1);
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++; $display("FAIL strobe_len: got %b want 0", key_valid);
    end
    tick(11);
    keys = 16'h0;
    for (int i = 0; i < 80 && key_held; i++) tick(1);
    n_cmp++;
    if (key_held !== 1'b0 || kc !== 112) begin
      n_bad++;
      $display("FAIL release: got held=%b at k=%0d want 0 at k=112",
               key_held, kc);
    end
    n_cmp++;
    if (key_code !== 4'h9 || vcount !== 1) begin
      n_bad++;
      $display("FAIL code_keep: got code=%h pulses=%0d want 9/1",
               key_code, vcount);
    end
  endtask

  task automatic test_bounce;
    keys = 16'h0;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      keys[3] = ~keys[3];
      tick(20);
    end
    n_cmp++;
    if (vcount !== 0) begin
      n_bad++; $display("FAIL bounce_quiet: got %0d pulses want 0", vcount);
    end
    for (int i = 0; i < 64 && !key_valid; i++) tick(1);
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h3 || kc !== 128) begin
      n_bad++;
      $display("FAIL bounce_acc: got v=%b code=%h k=%0d want 1/3/128",
               key_valid, key_code, kc);
    end
    keys = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) tick(1);
    n_cmp++;
    if (key_held !== 1'b0 || vcount !== 1) begin
      n_bad++;
      $display("FAIL bounce_rel: got held=%b pulses=%0d want 0/1",
               key_held, vcount);
    end
  endtask

  task automatic test_two_keys;
    keys = 16'h4010;
    apply_reset();
    tick(96);
    n_cmp++;
    if (vcount !== 0 || key_held !== 1'b0) begin
      n_bad++;
      $display("FAIL two_keys: got pulses=%0d held=%b want 0/0",
               vcount, key_held);
    end
    keys = 16'h0010;
    for (int i = 0; i < 80 && !key_valid; i++) tick(1);
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h4 || kc !== 144) begin
      n_bad++;
      $display("FAIL single_left: got v=%b code=%h k=%0d want 1/4/144",
               key_valid, key_code, kc);
    end
    keys = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) tick(1);
    n_cmp++;
    if (key_held !== 1'b0 || vcount !== 1) begin
      n_bad++;
      $display("FAIL two_rel: got held=%b pulses=%0d want 0/1",
               key_held, vcount);
    end
  endtask

  task automatic test_add_key;
    keys = 16'h0020;
    apply_reset();
    for (int i = 0; i < 70 && !key_held; i++) tick(1);
    n_cmp++;
    if (key_held !== 1'b1 || key_code !== 4'h5 || kc !== 48) begin
      n_bad++;
      $display("FAIL add_acc: got h=%b code=%h k=%0d want 1/5/48",
               key_held, key_code, kc);
    end
    keys = keys | 16'h0400;
    tick(96);
    n_cmp++;
    if (key_held !== 1'b1 || key_code !== 4'h5 || vcount !== 1) begin
      n_bad++;
      $display("FAIL add_hold: got h=%b code=%h pulses=%0d want 1/5/1",
               key_held, key_code, vcount);
    end
    keys = 16'h0;
    for (int i = 0; i < 100 && key_held; i++) tick(1);
    n_cmp++;
    if (key_held !== 1'b0 || kc !== 192 || vcount !== 1) begin
      n_bad++;
      $display("FAIL add_rel: got h=%b k=%0d pulses=%0d want 0/192/1",
               key_held, kc, vcount);
    end
  endtask

  task automatic test_reset_mid;
    keys = 16'h8000;
    apply_reset();
    for (int i = 0; i < 70 && !key_held; i++) tick(1);
    tick(5);
    reset = 0;
    #1;
    n_cmp++;
    if ({col_n, key_code, key_valid, key_held} !== 10'b1110_0000_0_0) begin
      n_bad++;
      $display("FAIL async_rst: got col=%b code=%h v=%b h=%b want 1110/0/0/0",
               col_n, key_code, key_valid, key_held);
    end
    vcount = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    kc = 0;
    for (int i = 0; i < 70 && !key_valid; i++) tick(1);
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'hF || kc !== 48) begin
      n_bad++;
      $display("FAIL reaccept: got v=%b code=%h k=%0d want 1/F/48",
               key_valid, key_code, kc);
    end
    tick(1);
    n_cmp++;
    if (vcount !== 1 || key_held !== 1'b1) begin
      n_bad++;
      $display("FAIL reacc_once: got pulses=%0d held=%b want 1/1",
               vcount, key_held);
    end
  endtask

  initial begin
    reset = 0;
    keys = 16'h0;
    test_reset();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_add_key();
    test_reset_mid();
    n_cmp++;
    if (dbl !== 1'b0) begin
      n_bad++; $display("FAIL strobe_pair: got back-to-back strobe want none");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
